sampling_scheduler: RTL and testbench
=====================================

# sampling_scheduler

Sequencing controller that time-multiplexes one shared, single-lane, fixed-latency sampling datapath (piecewise-sqrt → ×ε → +mean) across all latent elements of a VAE layer. It accepts a full mean/variance vector over a valid/ready handshake and issues one element per cycle to the lane. It tracks in-flight elements with a latency shift register, collects results into an output buffer, and presents the complete sample vector over a second valid/ready handshake. It sits between the encoder output stage and the decoder input.

## Interface
- `N_LATENT`, 2, number of latent elements per vector (≥1)
- `BITSIZE`, 16, fixed-point word width (same Q format as datapath)
- `LAT`, 5, datapath latency in cycles from issue to result (≥1)

- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `in_valid` in 1 — input vector valid
- `in_ready` out 1 — scheduler can accept a vector
- `in_mean` in N_LATENT*BITSIZE — mean vector, element i at bits [(i+1)*BITSIZE-1 : i*BITSIZE]
- `in_var` in N_LATENT*BITSIZE — variance vector, same packing
- `dp_issue` out 1 — element presented to datapath this cycle
- `dp_mean`, `dp_var` out BITSIZE — element operands
- `dp_result` in BITSIZE — datapath output, sampled per tracker tap
- `out_valid` out 1 — sample vector complete
- `out_ready` in 1 — consumer accepts vector
- `out_z` out N_LATENT*BITSIZE — sample vector, same packing
- `busy` out 1 — high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `in_mean`/`in_var`, clear `issue_idx`/`collect_idx`, go to ISSUE.
- ISSUE
  - `dp_issue`=1; `dp_mean`/`dp_var` = latched element `issue_idx`.
  - `issue_idx` increments each cycle; when `issue_idx`==N_LATENT-1, go to DRAIN.
  - No stalls: the lane is free-running.
- DRAIN
  - `dp_issue`=0; `dp_mean`/`dp_var` hold their last values.
  - Wait for remaining results.
- Tracker
  - `vld_sr[0]` <= `dp_issue`; `vld_sr[k]` <= `vld_sr[k-1]`.
  - When `vld_sr[LAT-1]`=1: write `dp_result` into `out_z` slot `collect_idx`, then increment `collect_idx`.
  - Writing slot N_LATENT-1 moves the FSM to DONE, from ISSUE or DRAIN (ISSUE→DONE only if N_LATENT+LAT timing permits, otherwise via DRAIN).
- DONE
  - `out_valid`=1; `out_z` stable.
  - On `out_ready`: go to IDLE.
  - `in_ready`=0 in DONE, so no accept is possible in the same cycle as the output handshake.
- Counters are `IDX_W` = max(1, clog2(N_LATENT)) bits wide. They never wrap mid-job; they are cleared on each accept.
- No arithmetic is performed in this block; data passes through unmodified.
- Reset mid-operation:
  - All state clears and in-flight results are discarded.
  - `dp_result` is ignored until the next issue reaches the tap.
- Reset values:
  - `in_ready`=1 (IDLE) once `rst_n` deasserts.
  - `out_valid`=0, `dp_issue`=0, `busy`=0.
  - `dp_mean`/`dp_var`/`out_z`=0; `vld_sr`=0.

## Timing
- Accept handshake at edge T. Issue cycles are T+1 … T+N_LATENT.
- Element i result is captured at the end of cycle T+1+i+LAT.
- `out_valid` rises in cycle T+N_LATENT+LAT+1. Accept-to-`out_valid` latency is N_LATENT+LAT+1 cycles.
- Output handshake at edge U gives `in_ready`=1 in cycle U+1.
- Minimum vector period is N_LATENT+LAT+2 cycles, with `out_ready` held high.
- `out_valid` stays high, with `out_z` unchanged, for as long as `out_ready`=0.

## Configuration
- `SAMPLING_SCHED_EPS_CAPTURE_EN` defined:
  - Adds input `dp_eps` (BITSIZE) and output `out_eps` (N_LATENT*BITSIZE).
  - ε is captured on the same tap and into the same slot as `dp_result`.
  - `out_eps` resets to 0 and is valid with `out_valid`.
- Undefined: neither port nor the capture registers exist; behaviour is otherwise identical.

## Structure
- Package `sampling_sched_pkg`:
  - State enum typedef (IDLE=0, ISSUE=1, DRAIN=2, DONE=3).
  - `IDX_W` helper function.
  - Default `LAT`/`BITSIZE` constants.
- Sub-module `sampling_sched_tracker`:
  - LAT-deep valid shift register plus `collect_idx` counter.
  - Outputs a write strobe, the slot index and a last-slot flag.

## Test plan
- Basic: N=2, LAT=5, echo model (`dp_result`=`dp_mean`+`dp_var`), mean={0x0100,0x0200}, var={0x0010,0x0020}, `out_ready`=1 → `out_valid` 8 cycles after accept, `out_z`={0x0110,0x0220}, `dp_issue` high exactly 2 cycles.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `out_z` stable, `in_ready`=0 throughout; 1 cycle after `out_ready`=1, `in_ready`=1.
- Back-to-back: `in_valid` held high with two vectors → second accept occurs the cycle `in_ready` returns; period 9 cycles; both outputs correct.
- Reset mid-DRAIN: drop `rst_n` 3 cycles after accept → all outputs at reset values immediately; next vector yields only its own results, with no stale slot.
- Edge params: N=1, LAT=1 → latency 3 cycles; N=8, LAT=1 → ISSUE→DRAIN→DONE path, all 8 slots in order.
- With `SAMPLING_SCHED_EPS_CAPTURE_EN`: `dp_eps`=0x0A00+slot → `out_eps`={0x0A00,0x0A01}, aligned with `out_z`.

Source files
------------

// File: rtl/sampling_sched_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : sampling_sched_pkg
// Brief    : Shared state encoding, defaults and index-width helper.
// Revision : 1.0 - initial release
//==============================================================================
package sampling_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam int c_default_lat     = 5;
  localparam int c_default_bitsize = 16;

  // Slot counters need at least one bit even for a single-element vector.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sampling_sched_tracker.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : sampling_sched_tracker
// Brief    : Latency shift register for in-flight elements plus result slot
//            counter; strobes a write when an issued element reaches the tap.
// Revision : 1.0 - initial release
//==============================================================================
module sampling_sched_tracker
  import sampling_sched_pkg::*;
#(
  parameter int N_LATENT = 2,
  parameter int LAT      = c_default_lat,
  parameter int IDX_W    = idx_w(N_LATENT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             issue,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic             wr_last
);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_LATENT - 1);

  logic [LAT-1:0]   r_vld_sr;
  logic [IDX_W-1:0] r_collect_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_sr      <= '0;
      r_collect_idx <= '0;
    end else begin
      r_vld_sr[0] <= issue;
      for (int k = 1; k < LAT; k++) begin
        r_vld_sr[k] <= r_vld_sr[k-1];
      end
      // Holds on the last slot so the counter never wraps inside a job.
      if (clear) begin
        r_collect_idx <= '0;
      end else if (r_vld_sr[LAT-1] && (r_collect_idx != c_last_idx)) begin
        r_collect_idx <= r_collect_idx + IDX_W'(1);
      end
    end
  end

  assign wr_en   = r_vld_sr[LAT-1];
  assign wr_idx  = r_collect_idx;
  assign wr_last = (r_collect_idx == c_last_idx);

endmodule
`default_nettype wire

// File: rtl/sampling_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : sampling_scheduler
// Brief    : Time-multiplexes a vector of latent elements onto one fixed-
//            latency sampling lane and reassembles the results.
// Options  : SAMPLING_SCHED_EPS_CAPTURE_EN adds dp_eps input / out_eps output.
// Revision : 1.0 - initial release
//==============================================================================
module sampling_scheduler
  import sampling_sched_pkg::*;
#(
  parameter int N_LATENT = 2,
  parameter int BITSIZE  = c_default_bitsize,
  parameter int LAT      = c_default_lat
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_LATENT*BITSIZE-1:0] in_mean,
  input  logic [N_LATENT*BITSIZE-1:0] in_var,
  output logic                        dp_issue,
  output logic [BITSIZE-1:0]          dp_mean,
  output logic [BITSIZE-1:0]          dp_var,
  input  logic [BITSIZE-1:0]          dp_result,
`ifdef SAMPLING_SCHED_EPS_CAPTURE_EN
  input  logic [BITSIZE-1:0]          dp_eps,
  output logic [N_LATENT*BITSIZE-1:0] out_eps,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_LATENT*BITSIZE-1:0] out_z,
  output logic                        busy
);

  localparam int               IDX_W      = idx_w(N_LATENT);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_LATENT - 1);

  sched_state_t       r_state;
  logic [IDX_W-1:0]   r_issue_idx;
  logic               r_dp_issue;
  logic [BITSIZE-1:0] r_dp_mean;
  logic [BITSIZE-1:0] r_dp_var;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic [BITSIZE-1:0] r_mean [N_LATENT];
  logic [BITSIZE-1:0] r_var  [N_LATENT];
  logic [BITSIZE-1:0] r_z    [N_LATENT];

  logic [IDX_W-1:0]   w_next_idx;
  logic               w_accept;
  logic               w_wr_en;
  logic [IDX_W-1:0]   w_wr_idx;
  logic               w_wr_last;
  logic               w_done;

  assign w_next_idx = r_issue_idx + IDX_W'(1);
  assign w_accept   = (r_state == IDLE) && in_valid;
  assign w_done     = w_wr_en && w_wr_last;

  sampling_sched_tracker #(
    .N_LATENT (N_LATENT),
    .LAT      (LAT),
    .IDX_W    (IDX_W)
  ) u_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_accept),
    .issue   (r_dp_issue),
    .wr_en   (w_wr_en),
    .wr_idx  (w_wr_idx),
    .wr_last (w_wr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_issue_idx <= '0;
      r_dp_issue  <= 1'b0;
      r_dp_mean   <= '0;
      r_dp_var    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int i = 0; i < N_LATENT; i++) begin
        r_mean[i] <= '0;
        r_var[i]  <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N_LATENT; i++) begin
              r_mean[i] <= in_mean[i*BITSIZE +: BITSIZE];
              r_var[i]  <= in_var[i*BITSIZE +: BITSIZE];
            end
            r_issue_idx <= '0;
            r_dp_issue  <= 1'b1;
            r_dp_mean   <= in_mean[BITSIZE-1:0];
            r_dp_var    <= in_var[BITSIZE-1:0];
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Operands are preloaded one element ahead so the lane never stalls.
          if (r_issue_idx == c_last_idx) begin
            r_dp_issue <= 1'b0;
            r_state    <= DRAIN;
          end else begin
            r_issue_idx <= w_next_idx;
            r_dp_mean   <= r_mean[w_next_idx];
            r_dp_var    <= r_var[w_next_idx];
          end
          if (w_done) begin
            r_dp_issue  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DRAIN: begin
          if (w_done) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LATENT; i++) begin
        r_z[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_z[w_wr_idx] <= dp_result;
    end
  end

`ifdef SAMPLING_SCHED_EPS_CAPTURE_EN
  logic [BITSIZE-1:0] r_eps [N_LATENT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LATENT; i++) begin
        r_eps[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_eps[w_wr_idx] <= dp_eps;
    end
  end
`endif

  for (genvar gi = 0; gi < N_LATENT; gi++) begin : g_pack
    assign out_z[gi*BITSIZE +: BITSIZE] = r_z[gi];
`ifdef SAMPLING_SCHED_EPS_CAPTURE_EN
    assign out_eps[gi*BITSIZE +: BITSIZE] = r_eps[gi];
`endif
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign dp_issue  = r_dp_issue;
  assign dp_mean   = r_dp_mean;
  assign dp_var    = r_dp_var;

endmodule
`default_nettype wire

// File: tb/tb_sampling_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_sampling_scheduler
// Brief    : Scoreboard bench for sampling_scheduler with an echo datapath
//            (result = mean + var); second instance covers N=8, LAT=1.
// Revision : 1.0 - initial release
//==============================================================================
module tb_sampling_scheduler;

  localparam int N    = 2;
  localparam int LAT  = 5;
  localparam int B    = 16;
  localparam int W    = N * B;
  localparam int N8   = 8;
  localparam int LAT8 = 1;
  localparam int W8   = N8 * B;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_mean, in_var;
  logic          dp_issue;
  logic [B-1:0]  dp_mean, dp_var, dp_result;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_z;
  logic          busy;

  logic          in_valid8, in_ready8, dp_issue8, out_valid8, busy8;
  logic [W8-1:0] in_mean8, in_var8, out_z8;
  logic [B-1:0]  dp_mean8, dp_var8, dp_result8;
  logic          out_ready8 = 1'b1;

`ifdef SAMPLING_SCHED_EPS_CAPTURE_EN
  logic [B-1:0]  dp_eps;
  logic [W-1:0]  out_eps;
  logic [W8-1:0] out_eps8;
`endif

  int  n_cmp = 0;
  int  n_fail = 0;
  int  cyc = 0;
  bit  ready_lvl = 1'b1;
  bit  rand_ready = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sampling_scheduler #(.N_LATENT(N), .BITSIZE(B), .LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mean(in_mean), .in_var(in_var), .dp_issue(dp_issue),
    .dp_mean(dp_mean), .dp_var(dp_var), .dp_result(dp_result),
`ifdef SAMPLING_SCHED_EPS_CAPTURE_EN
    .dp_eps(dp_eps), .out_eps(out_eps),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .busy(busy)
  );

  sampling_scheduler #(.N_LATENT(N8), .BITSIZE(B), .LAT(LAT8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_mean(in_mean8), .in_var(in_var8), .dp_issue(dp_issue8),
    .dp_mean(dp_mean8), .dp_var(dp_var8), .dp_result(dp_result8),
`ifdef SAMPLING_SCHED_EPS_CAPTURE_EN
    .dp_eps(16'h0000), .out_eps(out_eps8),
`endif
    .out_valid(out_valid8), .out_ready(out_ready8), .out_z(out_z8), .busy(busy8)
  );

  // Echo datapath: LAT-stage pipe; idle taps carry a poison value.
  logic [B-1:0] pipe_val [LAT];
  logic         pipe_vld [LAT];
  always @(posedge clk) begin
    pipe_vld[0] <= dp_issue;
    pipe_val[0] <= dp_mean + dp_var;
    for (int k = 1; k < LAT; k++) begin
      pipe_vld[k] <= pipe_vld[k-1];
      pipe_val[k] <= pipe_val[k-1];
    end
  end
  assign dp_result = pipe_vld[LAT-1] ? pipe_val[LAT-1] : 16'hDEAD;

  always @(posedge clk) dp_result8 <= dp_issue8 ? (dp_mean8 + dp_var8) : 16'hBEEF;

`ifdef SAMPLING_SCHED_EPS_CAPTURE_EN
  logic [B-1:0] pipe_eps [LAT];
  int eps_cnt = 0;
  always @(posedge clk) begin
    pipe_eps[0] <= 16'(32'h0A00 + eps_cnt);
    for (int k = 1; k < LAT; k++) pipe_eps[k] <= pipe_eps[k-1];
    if (in_valid && in_ready) eps_cnt <= 0;
    else if (dp_issue) eps_cnt <= eps_cnt + 1;
  end
  assign dp_eps = pipe_eps[LAT-1];
`endif

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_lvl;
    end
  end

  task automatic chk(input string name, input logic [W8-1:0] act, input logic [W8-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  function automatic logic [W-1:0] ref_z(input logic [W-1:0] m, input logic [W-1:0] v);
    logic [W-1:0] z;
    for (int i = 0; i < N; i++) z[i*B +: B] = m[i*B +: B] + v[i*B +: B];
    return z;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[i*B +: B] = 16'($urandom);
    return r;
  endfunction

  function automatic logic [W8-1:0] rnd8();
    logic [W8-1:0] r;
    for (int i = 0; i < N8; i++) r[i*B +: B] = 16'($urandom);
    return r;
  endfunction

  typedef struct {
    logic [W-1:0] mean;
    logic [W-1:0] vr;
    logic [W-1:0] z;
    int           t_acc;
  } job_t;

  job_t exp_q[$];
  int   acc_q[$];
  job_t cur;
  int   cnt_issue = 0;
  bit   prev_ov = 1'b0;

  // Input side: record each accepted vector and check the operand stream.
  always @(negedge clk) begin : p_in_mon
    job_t j;
    if (rst_n && in_valid && in_ready) begin
      j.mean  = in_mean;
      j.vr    = in_var;
      j.z     = ref_z(in_mean, in_var);
      j.t_acc = cyc + 1;
      exp_q.push_back(j);
      acc_q.push_back(cyc + 1);
      cur       = j;
      cnt_issue = 0;
    end else if (rst_n && dp_issue) begin
      if (cnt_issue >= N) fail_now("extra_issue");
      else begin
        chk("dp_mean", dp_mean, cur.mean[cnt_issue*B +: B]);
        chk("dp_var", dp_var, cur.vr[cnt_issue*B +: B]);
      end
      cnt_issue++;
    end
  end

  // Output side: latency on the rising edge of out_valid, data on handshake.
  always @(negedge clk) begin : p_out_mon
    job_t j;
    logic [W-1:0] e_eps;
    if (rst_n) begin
      chk("in_ready_vs_busy", in_ready, !busy);
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) fail_now("out_valid_without_job");
        else begin
          chk("latency", cyc + 1 - exp_q[0].t_acc, N + LAT + 1);
          chk("issue_count", cnt_issue, N);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("out_hs_without_job");
        else begin
          j = exp_q.pop_front();
          chk("out_z", out_z, j.z);
`ifdef SAMPLING_SCHED_EPS_CAPTURE_EN
          for (int i = 0; i < N; i++) e_eps[i*B +: B] = 16'(32'h0A00 + i);
          chk("out_eps", out_eps, e_eps);
`else
          e_eps = '0;
`endif
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic [W-1:0] m, input logic [W-1:0] v, input bit hold);
    int g;
    in_mean  = m;
    in_var   = v;
    in_valid = 1'b1;
    g = 0;
    do begin @(negedge clk); g++; end while (!in_ready && g < 100);
    if (!in_ready) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || busy) && g < 300) begin @(negedge clk); g++; end
    if (exp_q.size() != 0 || busy) fail_now("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin : p_main
    int g, t8;
    logic [W8-1:0] m8, v8, e8;
    in_valid = 1'b0; in_mean = '0; in_var = '0; rst_n = 1'b0;
    in_valid8 = 1'b0; in_mean8 = '0; in_var8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dp_issue", dp_issue, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_z", out_z, 0);
    chk("rst_dp_mean", dp_mean, 0);
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector: out_z must become {0x0220, 0x0110}.
    send(32'h0200_0100, 32'h0020_0010, 1'b0);
    wait_idle();

    // Backpressure: output held for 10 cycles.
    ready_lvl = 1'b0;
    send(rnd(), rnd(), 1'b0);
    g = 0;
    while (!out_valid && g < 100) begin @(negedge clk); g++; end
    if (!out_valid || exp_q.size() == 0) fail_now("bp_out_valid_timeout");
    else begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_z", out_z, exp_q[0].z);
      end
    end
    @(posedge clk); #1; ready_lvl = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("in_ready_after_out_hs", in_ready, 1);
    wait_idle();

    // Back-to-back with in_valid held high.
    send(rnd(), rnd(), 1'b1);
    send(rnd(), rnd(), 1'b0);
    wait_idle();
    chk("b2b_period", acc_q[acc_q.size()-1] - acc_q[acc_q.size()-2], N + LAT + 2);

    // Reset three cycles after accept (lane draining).
    send(rnd(), rnd(), 1'b0);
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_dp_issue", dp_issue, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_z", out_z, 0);
    chk("mid_rst_dp_var", dp_var, 0);
    exp_q.delete();
    prev_ov = 1'b0;
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;
    send(rnd(), rnd(), 1'b0);
    wait_idle();

    // Randomized vectors with random consumer stalls.
    rand_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      send(rnd(), rnd(), 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rand_ready = 1'b0;
    wait_idle();

    // N=8, LAT=1: all slots in order, accept-to-valid latency N+LAT+1.
    for (int v = 0; v < 3; v++) begin
      m8 = rnd8();
      v8 = rnd8();
      for (int i = 0; i < N8; i++) e8[i*B +: B] = m8[i*B +: B] + v8[i*B +: B];
      in_mean8 = m8; in_var8 = v8; in_valid8 = 1'b1;
      g = 0;
      do begin @(negedge clk); g++; end while (!in_ready8 && g < 100);
      t8 = cyc + 1;
      @(posedge clk); #1; in_valid8 = 1'b0;
      g = 0;
      while (!out_valid8 && g < 100) begin @(negedge clk); g++; end
      if (!out_valid8) fail_now("edge8_timeout");
      else begin
        chk("edge8_latency", cyc + 1 - t8, N8 + LAT8 + 1);
        chk("edge8_out_z", out_z8, e8);
      end
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
